cpu_ctrl_fsm: RTL and testbench
===============================

# cpu_ctrl_fsm

Multi-cycle control sequencer for the 19-bit CPU datapath. It drives the fetch, decode and execute sequence: it issues instruction and operand memory requests and selects which register (PC, IR, A, B or C) loads each cycle through the shared `load_select` encoding. It also increments the PC and raises halt and error status. It sits between the instruction register / memory interface and the register-load mux of the datapath.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of cycles `mem_req` may stay high without `mem_ready` before a bus error.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `run` in 1: start enable, sampled only in IDLE.
- `opcode` in 5 (`OPCODE_SIZE`): IR[18:14]. Valid from DECODE onward.
- `mem_ready` in 1: memory has data or has accepted the request. Sampled only while `mem_req`=1.
- `mem_req` out 1: memory access request.
- `addr_sel` out 1: memory address source. 0 = PC, 1 = IR operand field.
- `load_en` out 1: register load strobe.
- `load_select` out 3: target register code. PC=000, IR=001, A=010, B=011, C=100.
- `pc_inc` out 1: PC += 1 this cycle.
- `alu_en` out 1: ALU evaluates; result is captured into C at the next WB.
- `instr_done` out 1: one-cycle pulse in the final cycle of every completed instruction.
- `halted` out 1: FSM is in HALT.
- `illegal_op` out 1: sticky; an undefined opcode was decoded.
- `bus_err` out 1: sticky; a memory timeout occurred.

## Operation
- Outputs are Moore-decoded from the state register, except `illegal_op` and `bus_err`, which are flops.
- Every output not listed for a state is 0. `load_select` is 000 whenever `load_en`=0.
- Reset (`rst_n`=0 at a clock edge):
  - state becomes IDLE;
  - wait counter clears;
  - `illegal_op` and `bus_err` clear;
  - all outputs read 0.
- Opcode map:
  - 00000 NOP
  - 00001 LDA, 00010 LDB, 00011 LDC (load A/B/C from memory at the operand address)
  - 01000–01111 ALU (result goes to C)
  - 10000 JMP (PC ← operand)
  - 11111 HLT
  - all other codes are illegal.
- States, outputs and transitions:
  - IDLE: no outputs. Goes to FETCH when `run`=1.
  - FETCH: `mem_req`=1, `addr_sel`=0. Goes to LOAD_IR when `mem_ready`=1.
  - LOAD_IR: `load_en`=1, `load_select`=001, `pc_inc`=1. Always goes to DECODE.
  - DECODE: no outputs. Next state by opcode:
    - NOP → FETCH, with `instr_done`=1 in this cycle;
    - LDx → MEM;
    - ALU → EXEC;
    - JMP → WB;
    - HLT → HALT;
    - illegal → HALT, and `illegal_op` sets.
  - MEM: `mem_req`=1, `addr_sel`=1. Goes to WB when `mem_ready`=1.
  - EXEC: `alu_en`=1. Always goes to WB.
  - WB: `load_en`=1 and `instr_done`=1. `load_select` = 010/011/100 for LDA/LDB/LDC, 100 for ALU, 000 for JMP. Always goes to FETCH.
  - HALT: `halted`=1. Leaves only on reset; `run` is ignored.
- The operation type is latched in DECODE. WB uses the latched value, not the live `opcode`.
- Wait counter:
  - width = clog2(MEM_TIMEOUT+1);
  - clears on entry to FETCH or MEM;
  - increments each cycle in FETCH or MEM while `mem_ready`=0;
  - when it equals MEM_TIMEOUT with `mem_ready` still 0, next state is HALT and `bus_err` sets;
  - `mem_ready`=1 in that same cycle wins: normal transition, no error;
  - saturates and never wraps.
- `mem_ready` outside FETCH and MEM is ignored.

## Timing
- Zero-wait memory (`mem_ready` high in the request cycle), cycles per instruction:
  - NOP 3 (FETCH, LOAD_IR, DECODE);
  - JMP 4;
  - LDx 5;
  - ALU 5.
- Each cycle of `mem_ready` delay adds one cycle to FETCH or MEM.
- The first `mem_req` appears in the cycle after `run` is sampled high in IDLE.
- HLT: `halted`=1 from the cycle after DECODE. HLT does not pulse `instr_done`.
- Reset asserted mid-instruction, including the middle of a memory wait:
  - the next cycle is IDLE with all outputs 0;
  - no partial `load_en` or `pc_inc` is issued afterwards;
  - sticky flags clear.

## Test plan
- Reset, then `run`=1 for 1 cycle, `mem_ready` always 1, opcode NOP → outputs 0 during reset. FETCH/LOAD_IR/DECODE repeat with period 3. `pc_inc` and `instr_done` pulse once per 3 cycles.
- LDB with `mem_ready` delayed 2 cycles in MEM → 7-cycle instruction. WB shows `load_en`=1 and `load_select`=011. `addr_sel`=1 only during MEM.
- ALU op 01010, then JMP → EXEC shows `alu_en`=1, then WB loads C (100). JMP WB loads PC (000) in its 4th cycle.
- `mem_ready` held 0 in FETCH with MEM_TIMEOUT=15 → HALT entered after 15 wait cycles. `bus_err`=1, `halted`=1. Repeat with `mem_ready`=1 in cycle 15 → no error.
- Opcode 00101, then separately 11111 → the first gives HALT with `illegal_op`=1. HLT gives `illegal_op`=0, `halted`=1 and no `instr_done`. `run` toggling in HALT has no effect.
- `rst_n`=0 during the MEM wait of an LDA → next cycle IDLE with all outputs 0 and flags cleared. No WB load follows. After `run`, execution restarts from FETCH.

Source files
------------

// File: rtl/cpu_ctrl_fsm_if.sv
// Control/handshake bundle between the CPU control sequencer (master) and the
// datapath / memory side (slave).
interface cpu_ctrl_fsm_if;
  localparam int OPCODE_SIZE = 5;

  logic                   run;
  logic [OPCODE_SIZE-1:0] opcode;
  logic                   mem_ready;
  logic                   mem_req;
  logic                   addr_sel;
  logic                   load_en;
  logic [2:0]             load_select;
  logic                   pc_inc;
  logic                   alu_en;
  logic                   instr_done;
  logic                   halted;
  logic                   illegal_op;
  logic                   bus_err;

  modport master (
    input  run, opcode, mem_ready,
    output mem_req, addr_sel, load_en, load_select, pc_inc, alu_en,
           instr_done, halted, illegal_op, bus_err
  );

  modport slave (
    output run, opcode, mem_ready,
    input  mem_req, addr_sel, load_en, load_select, pc_inc, alu_en,
           instr_done, halted, illegal_op, bus_err
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 19-bit CPU datapath.
// Outputs are Moore-decoded from the state register; illegal_op/bus_err are sticky flops.
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst_n,
  cpu_ctrl_fsm_if.master bus
);
  localparam int OPCODE_SIZE = 5;
  localparam int CNT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  localparam logic [2:0] SEL_PC = 3'b000;
  localparam logic [2:0] SEL_IR = 3'b001;
  localparam logic [2:0] SEL_A  = 3'b010;
  localparam logic [2:0] SEL_B  = 3'b011;
  localparam logic [2:0] SEL_C  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD_IR = 3'd2,
    S_DECODE  = 3'd3,
    S_MEM     = 3'd4,
    S_EXEC    = 3'd5,
    S_WB      = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_NOP = 3'd0,
    K_LDA = 3'd1,
    K_LDB = 3'd2,
    K_LDC = 3'd3,
    K_ALU = 3'd4,
    K_JMP = 3'd5,
    K_HLT = 3'd6,
    K_ILL = 3'd7
  } kind_t;

  function automatic kind_t decode_op(input logic [OPCODE_SIZE-1:0] op);
    kind_t k;
    casez (op)
      5'b00000: k = K_NOP;
      5'b00001: k = K_LDA;
      5'b00010: k = K_LDB;
      5'b00011: k = K_LDC;
      5'b01???: k = K_ALU;
      5'b10000: k = K_JMP;
      5'b11111: k = K_HLT;
      default:  k = K_ILL;
    endcase
    return k;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  kind_t            kind_r;
  kind_t            kind_s;
  kind_t            dec_s;
  logic             illegal_r;
  logic             bus_err_r;
  logic             set_illegal_s;
  logic             set_bus_err_s;

  logic             mem_req_s;
  logic             addr_sel_s;
  logic             load_en_s;
  logic [2:0]       load_select_s;
  logic             pc_inc_s;
  logic             alu_en_s;
  logic             instr_done_s;
  logic             halted_s;

  assign dec_s = decode_op(bus.opcode);

  // State, wait counter, latched operation type and sticky status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      kind_r    <= K_NOP;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      kind_r    <= kind_s;
      illegal_r <= illegal_r | set_illegal_s;
      bus_err_r <= bus_err_r | set_bus_err_s;
    end
  end

  // Next-state, wait-counter and flag-set logic.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    kind_s        = kind_r;
    set_illegal_s = 1'b0;
    set_bus_err_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.run) begin
          state_s = S_FETCH;
          cnt_s   = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH, S_MEM: begin
        // Ready in the timeout cycle itself still completes the access normally.
        if (bus.mem_ready) begin
          state_s = (state_r == S_FETCH) ? S_LOAD_IR : S_WB;
        end else if (cnt_r == CNT_MAX) begin
          state_s       = S_HALT;
          set_bus_err_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_LOAD_IR: state_s = S_DECODE;
      S_DECODE: begin
        kind_s = dec_s;
        case (dec_s)
          K_NOP: begin
            state_s = S_FETCH;
            cnt_s   = '0;
          end
          K_LDA, K_LDB, K_LDC: begin
            state_s = S_MEM;
            cnt_s   = '0;
          end
          K_ALU:   state_s = S_EXEC;
          K_JMP:   state_s = S_WB;
          K_HLT:   state_s = S_HALT;
          default: begin
            state_s       = S_HALT;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_EXEC: state_s = S_WB;
      S_WB: begin
        state_s = S_FETCH;
        cnt_s   = '0;
      end
      S_HALT:  state_s = S_HALT;
      default: state_s = S_IDLE;
    endcase
  end

  // Moore output decode; WB target comes from the operation latched in DECODE.
  always_comb begin
    mem_req_s     = 1'b0;
    addr_sel_s    = 1'b0;
    load_en_s     = 1'b0;
    load_select_s = SEL_PC;
    pc_inc_s      = 1'b0;
    alu_en_s      = 1'b0;
    instr_done_s  = 1'b0;
    halted_s      = 1'b0;
    case (state_r)
      S_FETCH: mem_req_s = 1'b1;
      S_LOAD_IR: begin
        load_en_s     = 1'b1;
        load_select_s = SEL_IR;
        pc_inc_s      = 1'b1;
      end
      S_DECODE: instr_done_s = (dec_s == K_NOP);
      S_MEM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = 1'b1;
      end
      S_EXEC: alu_en_s = 1'b1;
      S_WB: begin
        load_en_s    = 1'b1;
        instr_done_s = 1'b1;
        case (kind_r)
          K_LDA:        load_select_s = SEL_A;
          K_LDB:        load_select_s = SEL_B;
          K_LDC, K_ALU: load_select_s = SEL_C;
          default:      load_select_s = SEL_PC;
        endcase
      end
      S_HALT:  halted_s = 1'b1;
      default: halted_s = 1'b0;
    endcase
  end

  assign bus.mem_req     = mem_req_s;
  assign bus.addr_sel    = addr_sel_s;
  assign bus.load_en     = load_en_s;
  assign bus.load_select = load_select_s;
  assign bus.pc_inc      = pc_inc_s;
  assign bus.alu_en      = alu_en_s;
  assign bus.instr_done  = instr_done_s;
  assign bus.halted      = halted_s;
  assign bus.illegal_op  = illegal_r;
  assign bus.bus_err     = bus_err_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench: builds a per-cycle table of inputs and expected outputs from the
// instruction timing rules, then replays it against cpu_ctrl_fsm and compares each cycle.
module tb_cpu_ctrl_fsm;
  localparam int TO = 15;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_LDA = 5'b00001;
  localparam logic [4:0] OP_LDB = 5'b00010;
  localparam logic [4:0] OP_LDC = 5'b00011;
  localparam logic [4:0] OP_ALU = 5'b01010;
  localparam logic [4:0] OP_JMP = 5'b10000;
  localparam logic [4:0] OP_HLT = 5'b11111;
  localparam logic [4:0] OP_BAD = 5'b00101;

  logic clk = 1'b0;
  logic rst_n;

  cpu_ctrl_fsm_if bus();

  cpu_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       addr_sel;
    logic       load_en;
    logic [2:0] load_select;
    logic       pc_inc;
    logic       alu_en;
    logic       instr_done;
    logic       halted;
    logic       illegal_op;
    logic       bus_err;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [4:0] op;
    logic       rdy;
    bit         chk;
    outs_t      want;
    string      tag;
  } ent_t;

  ent_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   ill_m       = 1'b0;
  bit   bus_m       = 1'b0;

  function automatic outs_t o(bit mreq, bit asel, bit len, logic [2:0] lsel,
                              bit pinc, bit alu, bit done, bit hlt);
    outs_t r;
    r.mem_req     = mreq;
    r.addr_sel    = asel;
    r.load_en     = len;
    r.load_select = lsel;
    r.pc_inc      = pinc;
    r.alu_en      = alu;
    r.instr_done  = done;
    r.halted      = hlt;
    r.illegal_op  = ill_m;
    r.bus_err     = bus_m;
    return r;
  endfunction

  function automatic outs_t o_z();
    return o(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic outs_t o_fetch();
    return o(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic outs_t o_mem();
    return o(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic outs_t o_ldir();
    return o(1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic outs_t o_exec();
    return o(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic outs_t o_wb(logic [2:0] sel);
    return o(1'b0, 1'b0, 1'b1, sel, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic outs_t o_dec(bit done);
    return o(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, done, 1'b0);
  endfunction
  function automatic outs_t o_halt();
    return o(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic cyc(logic rst, logic run_i, logic [4:0] op, logic rdy, bit chk,
                     outs_t want, string tag);
    ent_t x;
    x.rst  = rst;
    x.run  = run_i;
    x.op   = op;
    x.rdy  = rdy;
    x.chk  = chk;
    x.want = want;
    x.tag  = tag;
    q.push_back(x);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, OP_NOP, 1'b1, 1'b0, o_z(), "reset");
    ill_m = 1'b0;
    bus_m = 1'b0;
    cyc(1'b1, 1'b0, OP_NOP, 1'b1, 1'b1, o_z(), "idle");
  endtask

  task automatic start(logic [4:0] op);
    cyc(1'b1, 1'b1, op, 1'b1, 1'b1, o_z(), "idle_run");
  endtask

  task automatic fetch(logic [4:0] op, int w);
    for (int i = 0; i < w; i++) cyc(1'b1, 1'b0, op, 1'b0, 1'b1, o_fetch(), "fetch_wait");
    cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_fetch(), "fetch");
    cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_ldir(), "load_ir");
  endtask

  // One instruction from FETCH to its last cycle; wb_op is driven on opcode during WB.
  task automatic instr(logic [4:0] op, int fw, int mw, logic [4:0] wb_op);
    logic [2:0] sel;
    fetch(op, fw);
    if (op == OP_NOP) begin
      cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_dec(1'b1), "decode_nop");
    end else if (op == OP_LDA || op == OP_LDB || op == OP_LDC) begin
      sel = (op == OP_LDA) ? 3'b010 : (op == OP_LDB) ? 3'b011 : 3'b100;
      cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_dec(1'b0), "decode_ld");
      for (int i = 0; i < mw; i++) cyc(1'b1, 1'b0, op, 1'b0, 1'b1, o_mem(), "mem_wait");
      cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_mem(), "mem");
      cyc(1'b1, 1'b0, wb_op, 1'b1, 1'b1, o_wb(sel), "wb_ld");
    end else if (op[4:3] == 2'b01) begin
      cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_dec(1'b0), "decode_alu");
      cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_exec(), "exec");
      cyc(1'b1, 1'b0, wb_op, 1'b1, 1'b1, o_wb(3'b100), "wb_alu");
    end else if (op == OP_JMP) begin
      cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_dec(1'b0), "decode_jmp");
      cyc(1'b1, 1'b0, wb_op, 1'b1, 1'b1, o_wb(3'b000), "wb_jmp");
    end else if (op == OP_HLT) begin
      cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_dec(1'b0), "decode_hlt");
    end else begin
      cyc(1'b1, 1'b0, op, 1'b1, 1'b1, o_dec(1'b0), "decode_ill");
      ill_m = 1'b1;
    end
  endtask

  task automatic halt_cycles(logic [4:0] op, int n);
    for (int i = 0; i < n; i++) begin
      bit t;
      t = (i % 2) == 1;
      cyc(1'b1, t, op, t, 1'b1, o_halt(), "halt");
    end
  endtask

  task automatic pin(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s cycle count got=%0d required=%0d", name, got, want);
    end
  endtask

  initial begin
    int n;
    outs_t got;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = OP_NOP;
    bus.mem_ready = 1'b0;

    // NOP stream, period 3
    do_reset();
    start(OP_NOP);
    n = q.size(); instr(OP_NOP, 0, 0, OP_NOP); pin("nop", q.size() - n, 3);
    instr(OP_NOP, 0, 0, OP_NOP);
    instr(OP_NOP, 0, 0, OP_NOP);
    n = q.size(); instr(OP_LDB, 0, 2, OP_HLT); pin("ldb_wait2", q.size() - n, 7);
    n = q.size(); instr(OP_LDA, 1, 0, OP_JMP); pin("lda_fetchwait1", q.size() - n, 6);
    n = q.size(); instr(OP_ALU, 0, 0, OP_NOP); pin("alu", q.size() - n, 5);
    n = q.size(); instr(OP_JMP, 0, 0, OP_LDA); pin("jmp", q.size() - n, 4);
    n = q.size(); instr(OP_LDC, 0, 0, 5'b01000); pin("ldc", q.size() - n, 5);
    instr(5'b01111, 0, 0, OP_LDB);
    // ready arrives exactly in the counter==TO cycle: no error
    n = q.size(); instr(OP_NOP, TO, 0, OP_NOP); pin("fetch_boundary", q.size() - n, TO + 3);
    // ready never arrives in FETCH: bus error
    n = q.size();
    for (int i = 0; i <= TO; i++) cyc(1'b1, 1'b0, OP_NOP, 1'b0, 1'b1, o_fetch(), "fetch_to");
    pin("fetch_timeout", q.size() - n, 16);
    bus_m = 1'b1;
    halt_cycles(OP_NOP, 4);

    // timeout while in MEM
    do_reset();
    start(OP_LDB);
    fetch(OP_LDB, 0);
    cyc(1'b1, 1'b0, OP_LDB, 1'b1, 1'b1, o_dec(1'b0), "decode_ld");
    for (int i = 0; i <= TO; i++) cyc(1'b1, 1'b0, OP_LDB, 1'b0, 1'b1, o_mem(), "mem_to");
    bus_m = 1'b1;
    halt_cycles(OP_LDB, 3);

    // illegal opcode
    do_reset();
    start(OP_BAD);
    instr(OP_BAD, 0, 0, OP_BAD);
    halt_cycles(OP_BAD, 4);

    // HLT: no instr_done, halted only
    do_reset();
    start(OP_HLT);
    n = q.size(); instr(OP_HLT, 0, 0, OP_HLT); pin("hlt", q.size() - n, 3);
    halt_cycles(OP_HLT, 6);

    // reset in the middle of an LDA memory wait
    do_reset();
    start(OP_LDA);
    fetch(OP_LDA, 0);
    cyc(1'b1, 1'b0, OP_LDA, 1'b1, 1'b1, o_dec(1'b0), "decode_ld");
    cyc(1'b1, 1'b0, OP_LDA, 1'b0, 1'b1, o_mem(), "mem_wait");
    cyc(1'b1, 1'b0, OP_LDA, 1'b0, 1'b1, o_mem(), "mem_wait");
    cyc(1'b0, 1'b0, OP_LDA, 1'b1, 1'b1, o_mem(), "mem_at_reset");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, OP_LDA, 1'b1, 1'b1, o_z(), "idle_after_rst");
    start(OP_LDA);
    instr(OP_LDA, 0, 0, OP_NOP);
    instr(OP_NOP, 2, 0, OP_NOP);

    foreach (q[i]) begin
      @(negedge clk);
      rst_n         = q[i].rst;
      bus.run       = q[i].run;
      bus.opcode    = q[i].op;
      bus.mem_ready = q[i].rdy;
      #1;
      if (q[i].chk) begin
        got = {bus.mem_req, bus.addr_sel, bus.load_en, bus.load_select, bus.pc_inc,
               bus.alu_en, bus.instr_done, bus.halted, bus.illegal_op, bus.bus_err};
        vectors++;
        if (got !== q[i].want) begin
          miscompares++;
          $display("FAIL cycle %0d %s: got req/asel/len/sel/pinc/alu/done/halt/ill/berr=%b required=%b",
                   i, q[i].tag, got, q[i].want);
        end
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
